shared_ram_arbiter: RTL and testbench
=====================================

# shared_ram_arbiter

Parametrised single-port shared RAM with one 32-bit CPU port (picorv32 native valid/ready) and `NUM_DMA` byte-wide peripheral DMA ports, e.g. USB endpoint buffers. Peripheral ports are arbitrated round-robin and take precedence over the CPU. An optional starvation guard gives the CPU a bounded worst-case latency. It replaces hand-wired single-peripheral RAM sharing in SoC top levels.

## Interface
Parameters:
- `NUM_DMA`, 2: number of byte-wide DMA ports (1..8).
- `AW`, 8: word-address width; RAM is 2^AW x 32 bits. Byte address width is `AW+2`.
- `CPU_WAIT_MAX`, 15: starvation-guard threshold in cycles; used only when the guard is compiled in.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst` in 1: synchronous reset, active-high.
- `i_cpu_valid` in 1: CPU request.
- `i_cpu_addr` in AW+2: CPU byte address; bits [1:0] are ignored.
- `i_cpu_wdata` in 32: CPU write data.
- `i_cpu_wstrb` in 4: byte write enables; 0 means read.
- `o_cpu_ready` out 1: one-cycle completion pulse.
- `o_cpu_rdata` out 32: read data, valid while `o_cpu_ready` is high.
- `i_dma_req` in NUM_DMA: per-port access request.
- `i_dma_wen` in NUM_DMA: 1 = write, 0 = read.
- `i_dma_addr` in NUM_DMA*(AW+2): flattened byte addresses; port k occupies slice k.
- `i_dma_wdata` in NUM_DMA*8: flattened write bytes.
- `o_dma_gnt` out NUM_DMA: combinational one-hot grant.
- `o_dma_rvalid` out NUM_DMA: read-data-valid, one cycle after a granted read.
- `o_dma_rdata` out 8: shared read byte, qualified by `o_dma_rvalid`.

## Operation
- The RAM performs one access per cycle. Each cycle has exactly one owner: a DMA port, the CPU, or none.
- A DMA access happens when `i_dma_req[k] & o_dma_gnt[k]` is high. An ungranted port keeps its request asserted, with address and data held stable.
- Round-robin pointer `rr_last` resets to NUM_DMA-1, so port 0 has priority first. The search starts at `rr_last+1` and wraps modulo NUM_DMA. `rr_last` updates to the granted index on every DMA grant.
- DMA write: the byte is replicated to all four lanes, and lane strobe = `1 << addr[1:0]`.
- DMA read: `addr[1:0]` is registered. The next cycle, `o_dma_rdata` is the selected lane and `o_dma_rvalid[k]` = 1.
- The CPU FSM has two states:
  - `CPU_IDLE`: when `i_cpu_valid` is high and no DMA is granted, the access is issued and the FSM goes to `CPU_RESP`.
  - `CPU_RESP`: `o_cpu_ready` = 1 and `o_cpu_rdata` = RAM word. The FSM returns to `CPU_IDLE`. No CPU access is accepted in this cycle; a DMA access may be granted.
- CPU write uses `i_cpu_wstrb` directly. Reads with wstrb = 0 do not modify the RAM.
- Address bits above AW+1 are not present. Out-of-range decoding is the top level's job.

## Timing
- `o_dma_gnt` is combinational from `i_dma_req` and the arbiter state. There is no combinational path from `i_cpu_*` to `o_dma_gnt` except through the guard counter, which is registered.
- DMA read latency: 1 cycle. DMA write completes in the grant cycle.
- CPU latency: accepted in cycle N gives `o_cpu_ready` in cycle N+1. Minimum spacing between back-to-back CPU accesses is 2 cycles.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset values:
  - `o_cpu_ready` = 0, `o_dma_rvalid` = 0, FSM = `CPU_IDLE`.
  - `rr_last` = NUM_DMA-1, guard counter = 0, lane register = 0.
  - `o_cpu_rdata` and `o_dma_rdata` are undefined until the first read. RAM contents are not cleared.
- Reset during a pending `CPU_RESP` or DMA read drops the response: no ready/rvalid pulse follows.

## Configuration
- Macro: `SHARED_RAM_CPU_STARVE_GUARD_EN`.
- Defined:
  - A counter increments every cycle the CPU is valid in `CPU_IDLE` and not accepted. It clears on accept and on reset.
  - When the counter equals `CPU_WAIT_MAX`, all `o_dma_gnt` = 0 that cycle and the CPU is accepted.
  - Worst-case CPU latency = `CPU_WAIT_MAX`+2 cycles.
- Undefined: DMA always wins, the counter is absent, and the CPU may starve indefinitely.

## Structure
- Package `shared_ram_pkg`: CPU FSM state encodings (`CPU_IDLE`, `CPU_RESP`), lane-strobe function (`addr[1:0]` to 4-bit one-hot), lane-select function (32-bit word plus `addr[1:0]` to byte).
- Sub-module `shared_ram_bank`: four 8-bit `spram` instances of depth 2^AW, with common `ce`/`addr` and per-lane `we`.
- Arbiter, round-robin pointer, CPU FSM and guard live in `shared_ram_arbiter`.

## Test plan
- CPU alone: write 0xDEADBEEF with wstrb = 0xF to address 0x10, then read it back. Expect ready 1 cycle after each accept and rdata = 0xDEADBEEF.
- DMA byte write: port 1 writes 0xA5 to byte address 0x13. A CPU read of 0x10 then returns 0xA5ADBEEF; a port 0 read of 0x13 gives rvalid[0] the next cycle with rdata = 0xA5.
- Round robin: NUM_DMA = 3, all requests held high for 6 cycles. Expect grants 0,1,2,0,1,2, and CPU valid throughout gets no ready (guard undefined).
- Guard, with macro defined and CPU_WAIT_MAX = 4: DMA ports saturate and the CPU is valid from cycle 0. Expect CPU accepted in cycle 4 with `o_dma_gnt` = 0, and ready in cycle 5.
- Reset mid-transaction: assert `i_rst` in the `CPU_RESP` cycle and in a cycle after a DMA read grant. Expect no `o_cpu_ready`/`o_dma_rvalid` pulse afterwards and the next grant going to port 0.

Source files
------------

// File: rtl/shared_ram_pkg.sv
// ----------------------------------------------------------------------------
// shared_ram_pkg
// Shared definitions for the shared RAM arbiter:
//   - CPU handshake FSM state encodings (CPU_IDLE, CPU_RESP)
//   - lane_strobe : byte offset addr[1:0] -> 4-bit one-hot lane write strobe
//   - lane_select : 32-bit RAM word + addr[1:0] -> addressed byte
// ----------------------------------------------------------------------------
package shared_ram_pkg;

    localparam logic [0:0] CPU_IDLE = 1'b0;
    localparam logic [0:0] CPU_RESP = 1'b1;

    function automatic logic [3:0] lane_strobe(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [7:0] lane_select(input logic [31:0] word,
                                               input logic [1:0]  lane);
        return word[lane*8 +: 8];
    endfunction

endpackage

// File: rtl/shared_ram_bank.sv
// ----------------------------------------------------------------------------
// shared_ram_bank
// 32-bit wide RAM built from four byte-wide spram lanes sharing one address
// and enable, each lane with its own write enable.
// Ports:
//   clk   : clock
//   ce    : access enable
//   addr  : word address (AW bits)
//   we    : per-lane write enables, bit n writes wdata[8n+7:8n]
//   wdata : 32-bit write word
//   rdata : 32-bit read word, one cycle after the access
// ----------------------------------------------------------------------------
module shared_ram_bank #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar n = 0; n < 4; n++) begin : g_lane
        spram #(
            .DW(8),
            .AW(AW)
        ) u_spram (
            .clk  (clk),
            .ce   (ce),
            .we   (we[n]),
            .addr (addr),
            .wdata(wdata[n*8 +: 8]),
            .rdata(rdata[n*8 +: 8])
        );
    end

endmodule

// File: rtl/spram.sv
// ----------------------------------------------------------------------------
// spram
// Single-port synchronous RAM, 2^AW x DW, registered read data.
// Ports:
//   clk   : clock
//   ce    : access enable (read and/or write this cycle)
//   we    : write enable, qualified by ce
//   addr  : word address
//   wdata : write data
//   rdata : read data of the last enabled access (old contents on a write)
// ----------------------------------------------------------------------------
module spram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the storage array has no reset on purpose; a reset loop over a
    // memory would prevent block-RAM inference and the contents are not
    // required to be cleared.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/shared_ram_arbiter.sv
// ----------------------------------------------------------------------------
// shared_ram_arbiter
// Single-port 2^AW x 32 RAM shared between one 32-bit CPU port (valid/ready)
// and NUM_DMA byte-wide DMA ports. DMA ports are served round-robin and take
// precedence over the CPU.
//
// Optional feature macro: SHARED_RAM_CPU_STARVE_GUARD_EN
//   When defined, a registered wait counter blocks all DMA grants for one
//   cycle once the CPU has waited CPU_WAIT_MAX cycles, bounding CPU latency.
//
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_cpu_valid       : CPU request
//   i_cpu_addr        : CPU byte address (bits [1:0] ignored)
//   i_cpu_wdata       : CPU write word
//   i_cpu_wstrb       : CPU byte write enables, 0 = read
//   o_cpu_ready       : one-cycle completion pulse
//   o_cpu_rdata       : read word, valid with o_cpu_ready
//   i_dma_req         : per-port request
//   i_dma_wen         : per-port write (1) / read (0)
//   i_dma_addr        : flattened per-port byte addresses
//   i_dma_wdata       : flattened per-port write bytes
//   o_dma_gnt         : combinational one-hot grant
//   o_dma_rvalid      : per-port read valid, one cycle after a granted read
//   o_dma_rdata       : shared read byte, qualified by o_dma_rvalid
// ----------------------------------------------------------------------------
module shared_ram_arbiter
    import shared_ram_pkg::*;
#(
    parameter int NUM_DMA      = 2,
    parameter int AW           = 8,
    parameter int CPU_WAIT_MAX = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cpu_valid,
    input  logic [AW+1:0]             i_cpu_addr,
    input  logic [31:0]               i_cpu_wdata,
    input  logic [3:0]                i_cpu_wstrb,
    output logic                      o_cpu_ready,
    output logic [31:0]               o_cpu_rdata,
    input  logic [NUM_DMA-1:0]        i_dma_req,
    input  logic [NUM_DMA-1:0]        i_dma_wen,
    input  logic [NUM_DMA*(AW+2)-1:0] i_dma_addr,
    input  logic [NUM_DMA*8-1:0]      i_dma_wdata,
    output logic [NUM_DMA-1:0]        o_dma_gnt,
    output logic [NUM_DMA-1:0]        o_dma_rvalid,
    output logic [7:0]                o_dma_rdata
);

    localparam int BAW = AW + 2;
    localparam int IW  = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;

    logic [0:0]         cpu_state;
    logic [IW-1:0]      rr_last;
    logic [IW-1:0]      gnt_idx;
    logic [IW-1:0]      cand;
    logic               found;
    logic [NUM_DMA-1:0] dma_gnt;
    logic [NUM_DMA-1:0] rvalid_q;
    logic [1:0]         lane_q;
    logic               guard_block;
    logic               dma_access;
    logic               cpu_accept;

    logic [BAW-1:0]     sel_addr;
    logic [7:0]         sel_wdata;
    logic               sel_wen;

    logic               ram_ce;
    logic [AW-1:0]      ram_addr;
    logic [3:0]         ram_we;
    logic [31:0]        ram_wdata;
    logic [31:0]        ram_rdata;

    // Round-robin search starting just after the last granted port.
    // NOTE: every variable driven here gets a default first so no latch is
    // inferred on paths where no port is requesting.
    always_comb begin
        dma_gnt = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 1; i <= NUM_DMA; i++) begin
            cand = IW'((int'(rr_last) + i) % NUM_DMA);
            if (!found && i_dma_req[cand]) begin
                found         = 1'b1;
                dma_gnt[cand] = 1'b1;
                gnt_idx       = cand;
            end
        end
        if (guard_block) begin
            dma_gnt = '0;
        end
    end

    assign dma_access = |dma_gnt;
    assign cpu_accept = (cpu_state == CPU_IDLE) && i_cpu_valid && !dma_access;

    assign sel_addr  = i_dma_addr[gnt_idx*BAW +: BAW];
    assign sel_wdata = i_dma_wdata[gnt_idx*8 +: 8];
    assign sel_wen   = i_dma_wen[gnt_idx];

    // RAM port mux: the DMA owner wins; the byte is replicated on all lanes
    // and only the addressed lane is strobed.
    always_comb begin
        ram_ce = (dma_access || cpu_accept) && !i_rst;
        if (dma_access) begin
            ram_addr  = sel_addr[BAW-1:2];
            ram_we    = sel_wen ? lane_strobe(sel_addr[1:0]) : 4'b0000;
            ram_wdata = {4{sel_wdata}};
        end else begin
            ram_addr  = i_cpu_addr[BAW-1:2];
            ram_we    = cpu_accept ? i_cpu_wstrb : 4'b0000;
            ram_wdata = i_cpu_wdata;
        end
    end

    shared_ram_bank #(
        .AW(AW)
    ) u_bank (
        .clk  (i_clk),
        .ce   (ram_ce),
        .addr (ram_addr),
        .we   (ram_we),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cpu_state <= CPU_IDLE;
            rr_last   <= IW'(NUM_DMA - 1);
            rvalid_q  <= '0;
            lane_q    <= '0;
        end else begin
            cpu_state <= cpu_accept ? CPU_RESP : CPU_IDLE;
            rvalid_q  <= dma_gnt & ~i_dma_wen;
            if (dma_access) begin
                rr_last <= gnt_idx;
                if (!sel_wen) begin
                    lane_q <= sel_addr[1:0];
                end
            end
        end
    end

`ifdef SHARED_RAM_CPU_STARVE_GUARD_EN
    localparam int GW = $clog2(CPU_WAIT_MAX + 1);

    logic [GW-1:0] wait_cnt;

    // Counts cycles the CPU has been left waiting; reaching the threshold
    // hands the next cycle to the CPU. Registered, so i_cpu_* never reaches
    // o_dma_gnt combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt <= '0;
        end else if (cpu_accept) begin
            wait_cnt <= '0;
        end else if ((cpu_state == CPU_IDLE) && i_cpu_valid) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign guard_block = (wait_cnt == GW'(CPU_WAIT_MAX));
`else
    logic unused_cfg;
    assign unused_cfg  = (CPU_WAIT_MAX == 0);
    assign guard_block = 1'b0;
`endif

    // Responses in flight are suppressed while reset is asserted.
    assign o_dma_gnt    = dma_gnt;
    assign o_cpu_ready  = (cpu_state == CPU_RESP) && !i_rst;
    assign o_cpu_rdata  = ram_rdata;
    assign o_dma_rvalid = rvalid_q & {NUM_DMA{!i_rst}};
    assign o_dma_rdata  = lane_select(ram_rdata, lane_q);

    logic unused_addr;
    assign unused_addr = ^i_cpu_addr[1:0];

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_shared_ram_arbiter
// Directed bench for shared_ram_arbiter with NUM_DMA=3, AW=8, CPU_WAIT_MAX=4.
// Inputs change 1 ns after the rising edge; outputs are compared 2 ns after
// the rising edge, so each compare belongs to the cycle ending at the next
// rising edge.
// ----------------------------------------------------------------------------
module tb_shared_ram_arbiter;

    localparam int ND  = 3;
    localparam int AW  = 8;
    localparam int BAW = AW + 2;

    logic              clk;
    logic              rst;
    logic              cpu_valid;
    logic [BAW-1:0]    cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wstrb;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic [ND-1:0]     dma_req;
    logic [ND-1:0]     dma_wen;
    logic [ND*BAW-1:0] dma_addr;
    logic [ND*8-1:0]   dma_wdata;
    logic [ND-1:0]     dma_gnt;
    logic [ND-1:0]     dma_rvalid;
    logic [7:0]        dma_rdata;

    int errors = 0;
    int checks = 0;

    shared_ram_arbiter #(
        .NUM_DMA     (ND),
        .AW          (AW),
        .CPU_WAIT_MAX(4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_valid (cpu_valid),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .i_cpu_wstrb (cpu_wstrb),
        .o_cpu_ready (cpu_ready),
        .o_cpu_rdata (cpu_rdata),
        .i_dma_req   (dma_req),
        .i_dma_wen   (dma_wen),
        .i_dma_addr  (dma_addr),
        .i_dma_wdata (dma_wdata),
        .o_dma_gnt   (dma_gnt),
        .o_dma_rvalid(dma_rvalid),
        .o_dma_rdata (dma_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
        dma_req   = '0;
        dma_wen   = '0;
        dma_addr  = '0;
        dma_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_dma(input int k, input logic wen,
                           input logic [BAW-1:0] addr, input logic [7:0] data);
        dma_req[k]             = 1'b1;
        dma_wen[k]             = wen;
        dma_addr[k*BAW +: BAW] = addr;
        dma_wdata[k*8 +: 8]    = data;
    endtask

    // One CPU transaction issued with no DMA traffic: accept this cycle,
    // ready next cycle, optional read-data compare.
    task automatic cpu_access(input logic [BAW-1:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic chk_rdata,
                              input logic [31:0] exp_rdata, input string name);
        cpu_valid = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        #1;
        checks++;
        if (cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s accept-cycle ready: got %b want 0", name, cpu_ready);
        end
        step();
        #1;
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b want 1", name, cpu_ready);
        end
        if (chk_rdata) begin
            checks++;
            if (cpu_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL %s rdata: got %h want %h", name, cpu_rdata, exp_rdata);
            end
        end
        cpu_valid = 1'b0;
        cpu_wstrb = '0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset cpu_ready: got %b want 0", cpu_ready);
        end
        checks++;
        if (dma_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL reset dma_rvalid: got %b want 000", dma_rvalid);
        end
        checks++;
        if (dma_gnt !== 3'b000) begin
            errors++;
            $display("FAIL reset idle gnt: got %b want 000", dma_gnt);
        end
        dma_req = 3'b111;
        #1;
        checks++;
        if (dma_gnt !== 3'b001) begin
            errors++;
            $display("FAIL reset first gnt: got %b want 001", dma_gnt);
        end
        dma_req = '0;
        step();
    endtask

    task automatic test_cpu_alone();
        cpu_access(10'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, "cpu_write");
        cpu_access(10'h010, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, "cpu_read");
    endtask

    task automatic test_dma_write_read();
        set_dma(1, 1'b1, 10'h013, 8'hA5);
        #1;
        checks++;
        if (dma_gnt !== 3'b010) begin
            errors++;
            $display("FAIL dma1_write gnt: got %b want 010", dma_gnt);
        end
        step();
        dma_req = '0;
        cpu_access(10'h010, 32'h0, 4'h0, 1'b1, 32'hA5ADBEEF, "cpu_read_after_dma1");

        set_dma(2, 1'b1, 10'h011, 8'h3C);
        #1;
        checks++;
        if (dma_gnt !== 3'b100) begin
            errors++;
            $display("FAIL dma2_write gnt: got %b want 100", dma_gnt);
        end
        step();
        dma_req = '0;
        cpu_access(10'h010, 32'h0, 4'h0, 1'b1, 32'hA5AD3CEF, "cpu_read_after_dma2");

        set_dma(0, 1'b0, 10'h013, 8'h00);
        #1;
        checks++;
        if (dma_gnt !== 3'b001) begin
            errors++;
            $display("FAIL dma0_read gnt: got %b want 001", dma_gnt);
        end
        step();
        dma_req = '0;
        #1;
        checks++;
        if (dma_rvalid !== 3'b001) begin
            errors++;
            $display("FAIL dma0_read rvalid: got %b want 001", dma_rvalid);
        end
        checks++;
        if (dma_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL dma0_read rdata: got %h want a5", dma_rdata);
        end
        step();
        #1;
        checks++;
        if (dma_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL dma0_read rvalid pulse width: got %b want 000", dma_rvalid);
        end
        step();
    endtask

    // All three ports read lanes 0..2 of word 0x10 (A5AD3CEF).
    task automatic test_round_robin();
        logic [7:0] exp_byte [3];
        logic [2:0] exp_vec;
        exp_byte[0] = 8'hEF;
        exp_byte[1] = 8'h3C;
        exp_byte[2] = 8'hAD;
        do_reset();
        set_dma(0, 1'b0, 10'h010, 8'h00);
        set_dma(1, 1'b0, 10'h011, 8'h00);
        set_dma(2, 1'b0, 10'h012, 8'h00);
`ifndef SHARED_RAM_CPU_STARVE_GUARD_EN
        cpu_valid = 1'b1;
        cpu_addr  = 10'h010;
        cpu_wstrb = 4'h0;
`endif
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_vec = 3'b001 << (i % 3);
            checks++;
            if (dma_gnt !== exp_vec) begin
                errors++;
                $display("FAIL rr gnt cycle %0d: got %b want %b", i, dma_gnt, exp_vec);
            end
            checks++;
            if (cpu_ready !== 1'b0) begin
                errors++;
                $display("FAIL rr cpu starved ready cycle %0d: got %b want 0", i, cpu_ready);
            end
            if (i > 0) begin
                exp_vec = 3'b001 << ((i - 1) % 3);
                checks++;
                if (dma_rvalid !== exp_vec || dma_rdata !== exp_byte[(i-1)%3]) begin
                    errors++;
                    $display("FAIL rr read cycle %0d: got rvalid %b rdata %h want %b %h",
                             i, dma_rvalid, dma_rdata, exp_vec, exp_byte[(i-1)%3]);
                end
            end
            step();
        end
        dma_req = '0;
        #1;
        checks++;
        if (dma_rvalid !== 3'b100 || dma_rdata !== 8'hAD) begin
            errors++;
            $display("FAIL rr last read: got rvalid %b rdata %h want 100 ad",
                     dma_rvalid, dma_rdata);
        end
`ifndef SHARED_RAM_CPU_STARVE_GUARD_EN
        step();
        #1;
        checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hA5AD3CEF) begin
            errors++;
            $display("FAIL rr cpu after release: got ready %b rdata %h want 1 a5ad3cef",
                     cpu_ready, cpu_rdata);
        end
        cpu_valid = 1'b0;
`endif
        step();
    endtask

`ifdef SHARED_RAM_CPU_STARVE_GUARD_EN
    task automatic test_guard();
        logic [2:0] exp_vec;
        do_reset();
        set_dma(0, 1'b0, 10'h010, 8'h00);
        set_dma(1, 1'b0, 10'h011, 8'h00);
        set_dma(2, 1'b0, 10'h012, 8'h00);
        cpu_valid = 1'b1;
        cpu_addr  = 10'h010;
        cpu_wstrb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_vec = 3'b001 << (i % 3);
            checks++;
            if (dma_gnt !== exp_vec || cpu_ready !== 1'b0) begin
                errors++;
                $display("FAIL guard cycle %0d: got gnt %b ready %b want %b 0",
                         i, dma_gnt, cpu_ready, exp_vec);
            end
            step();
        end
        #1;
        checks++;
        if (dma_gnt !== 3'b000 || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL guard block cycle 4: got gnt %b ready %b want 000 0",
                     dma_gnt, cpu_ready);
        end
        step();
        #1;
        checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hA5AD3CEF) begin
            errors++;
            $display("FAIL guard ready cycle 5: got ready %b rdata %h want 1 a5ad3cef",
                     cpu_ready, cpu_rdata);
        end
        checks++;
        if (dma_gnt !== 3'b010 || dma_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL guard resume cycle 5: got gnt %b rvalid %b want 010 000",
                     dma_gnt, dma_rvalid);
        end
        cpu_valid = 1'b0;
        dma_req   = '0;
        step();
    endtask
`endif

    task automatic test_reset_mid();
        clear_inputs();
        cpu_valid = 1'b1;
        cpu_addr  = 10'h010;
        #1;
        checks++;
        if (cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid cpu accept ready: got %b want 0", cpu_ready);
        end
        step();
        cpu_valid = 1'b0;
        rst       = 1'b1;
        #1;
        checks++;
        if (cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid cpu ready during reset: got %b want 0", cpu_ready);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid cpu ready after reset: got %b want 0", cpu_ready);
        end

        set_dma(2, 1'b0, 10'h012, 8'h00);
        #1;
        checks++;
        if (dma_gnt !== 3'b100) begin
            errors++;
            $display("FAIL rstmid dma2 gnt: got %b want 100", dma_gnt);
        end
        step();
        dma_req = '0;
        rst     = 1'b1;
        #1;
        checks++;
        if (dma_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL rstmid rvalid during reset: got %b want 000", dma_rvalid);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (dma_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL rstmid rvalid after reset: got %b want 000", dma_rvalid);
        end
        dma_req = 3'b111;
        #1;
        checks++;
        if (dma_gnt !== 3'b001) begin
            errors++;
            $display("FAIL rstmid next gnt: got %b want 001", dma_gnt);
        end
        dma_req = '0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_cpu_alone();
        test_dma_write_read();
        test_round_robin();
`ifdef SHARED_RAM_CPU_STARVE_GUARD_EN
        test_guard();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
